// File: rtl/cp0_ctrl_if.sv
// Commit-stage <-> CP0 bundle: exception/interrupt inputs, MTC0/MFC0 port,
// flush/redirect outputs. The pipeline drives the master side.
interface cp0_ctrl_if #(
    parameter int HW_INT_NUM = 6
);
    logic                  commit_i;
    logic [7:0]            exc_req_i;
    logic [31:0]           pc_i;
    logic [31:0]           bad_addr_i;
    logic                  in_delayslot_i;
    logic [HW_INT_NUM-1:0] int_i;
    logic                  wen_i;
    logic [4:0]            waddr_i;
    logic [31:0]           wdata_i;
    logic [4:0]            raddr_i;
    logic [31:0]           rdata_o;
    logic                  flush_o;
    logic [31:0]           flush_pc_o;
    logic                  int_pending_o;
    logic                  timer_int_o;

    modport master (
        output commit_i, exc_req_i, pc_i, bad_addr_i, in_delayslot_i, int_i,
               wen_i, waddr_i, wdata_i, raddr_i,
        input  rdata_o, flush_o, flush_pc_o, int_pending_o, timer_int_o
    );

    modport slave (
        input  commit_i, exc_req_i, pc_i, bad_addr_i, in_delayslot_i, int_i,
               wen_i, waddr_i, wdata_i, raddr_i,
        output rdata_o, flush_o, flush_pc_o, int_pending_o, timer_int_o
    );
endinterface

// File: rtl/cp0_ctrl.sv
// CP0 system control: BadVAddr/Count/Compare/Status/Cause/EPC, exception and
// interrupt prioritisation at commit, registered one-cycle flush with redirect.
module cp0_ctrl #(
    parameter int          HW_INT_NUM   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380,
    parameter bit          TIMER_IP     = 1'b1,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input logic       clk,
    input logic       rst,
    cp0_ctrl_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [3:0]  PRESC_LAST   = 4'(COUNT_DIV - 1);

    logic [31:0] badvaddr, count, compare, status, epc, cause;
    logic        cause_bd, cause_ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [3:0]  presc;
    logic        flush;
    logic [31:0] flush_pc;

    logic [5:0]  int_ext;
    logic [7:0]  ip_eff;
    logic        int_pending;
    logic        exc_take, eret_take, event_take;
    logic [4:0]  exc_sel;
    logic        bad_upd;
    logic [31:0] bad_val;
    logic        wr;
    logic [31:0] count_next;
    logic [31:0] epc_byp;
    logic [31:0] rd_stored, rd_mask;

    // Hardware lines beyond HW_INT_NUM are tied off so their IP bits read 0.
    for (genvar i = 0; i < 6; i++) begin : g_int
        if (i < HW_INT_NUM) begin : g_used
            assign int_ext[i] = bus.int_i[i];
        end else begin : g_unused
            assign int_ext[i] = 1'b0;
        end
    end

    assign cause  = {cause_bd, cause_ti, 14'd0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};
    assign ip_eff = {ip_hw[5] | (TIMER_IP & cause_ti), ip_hw[4:0], ip_sw};
    assign int_pending = status[0] & ~status[1] & |(ip_eff & status[15:8]);

    always_comb begin
        exc_take  = 1'b0;
        eret_take = 1'b0;
        exc_sel   = EXC_INT;
        bad_upd   = 1'b0;
        bad_val   = bus.bad_addr_i;
        if (bus.commit_i) begin
            if (int_pending) begin
                exc_take = 1'b1;
            end else if (bus.exc_req_i[7]) begin
                exc_take = 1'b1; exc_sel = EXC_ADEL; bad_upd = 1'b1; bad_val = bus.pc_i;
            end else if (bus.exc_req_i[6]) begin
                exc_take = 1'b1; exc_sel = EXC_RI;
            end else if (bus.exc_req_i[5]) begin
                exc_take = 1'b1; exc_sel = EXC_OV;
            end else if (bus.exc_req_i[4]) begin
                exc_take = 1'b1; exc_sel = EXC_BP;
            end else if (bus.exc_req_i[3]) begin
                exc_take = 1'b1; exc_sel = EXC_SYS;
            end else if (bus.exc_req_i[2]) begin
                exc_take = 1'b1; exc_sel = EXC_ADEL; bad_upd = 1'b1;
            end else if (bus.exc_req_i[1]) begin
                exc_take = 1'b1; exc_sel = EXC_ADES; bad_upd = 1'b1;
            end else if (bus.exc_req_i[0]) begin
                eret_take = 1'b1;
            end
        end
    end

    assign event_take = exc_take | eret_take;
    // Any taken event squashes the MTC0 issued alongside it.
    assign wr      = bus.wen_i & ~event_take;
    assign epc_byp = (bus.wen_i && bus.waddr_i == REG_EPC) ? bus.wdata_i : epc;

    always_comb begin
        count_next = count;
        if (wr && bus.waddr_i == REG_COUNT) count_next = bus.wdata_i;
        else if (presc == PRESC_LAST)       count_next = count + 32'd1;
    end

    // Timer path runs independently of events; only the write squash reaches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            count    <= '0;
            compare  <= '0;
            cause_ti <= 1'b0;
        end else begin
            count <= count_next;
            if ((wr && bus.waddr_i == REG_COUNT) || presc == PRESC_LAST) presc <= '0;
            else                                                          presc <= presc + 4'd1;
            if (wr && bus.waddr_i == REG_COMPARE) begin
                compare  <= bus.wdata_i;
                cause_ti <= 1'b0;
            end else if (count_next == compare) begin
                cause_ti <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr <= '0;
            status   <= STATUS_RESET;
            epc      <= '0;
            cause_bd <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            ip_hw <= int_ext;
            flush <= event_take;
            if (exc_take) begin
                if (!status[1]) begin
                    epc      <= bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
                    cause_bd <= bus.in_delayslot_i;
                end
                status[1] <= 1'b1;
                exc_code  <= exc_sel;
                if (bad_upd) badvaddr <= bad_val;
                flush_pc  <= EXC_VECTOR;
            end else if (eret_take) begin
                status[1] <= 1'b0;
                flush_pc  <= epc_byp;
            end else if (wr) begin
                case (bus.waddr_i)
                    REG_STATUS: status <= (status & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
                    REG_CAUSE:  ip_sw  <= bus.wdata_i[9:8];
                    REG_EPC:    epc    <= bus.wdata_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_stored = '0;
        rd_mask   = '0;
        case (bus.raddr_i)
            REG_BADVADDR: rd_stored = badvaddr;
            REG_COUNT:    begin rd_stored = count;   rd_mask = '1; end
            REG_COMPARE:  begin rd_stored = compare; rd_mask = '1; end
            REG_STATUS:   begin rd_stored = status;  rd_mask = STATUS_WMASK; end
            REG_CAUSE:    begin rd_stored = cause;   rd_mask = CAUSE_WMASK; end
            REG_EPC:      begin rd_stored = epc;     rd_mask = '1; end
            default: ;
        endcase
    end

    assign bus.rdata_o = (bus.wen_i && bus.waddr_i == bus.raddr_i)
                         ? (rd_stored & ~rd_mask) | (bus.wdata_i & rd_mask)
                         : rd_stored;
    assign bus.flush_o       = flush;
    assign bus.flush_pc_o    = flush_pc;
    assign bus.int_pending_o = int_pending;
    assign bus.timer_int_o   = cause_ti;
endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench: instance a (defaults, COUNT_DIV=2) for reset/prescaler,
// instance b (COUNT_DIV=1, HW_INT_NUM=3) for timer, exceptions and ERET.
module tb_cp0_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #50 clk = ~clk;

    logic        commit = 1'b0;
    logic [7:0]  exc_req = '0;
    logic [31:0] pc = '0, bad_addr = '0, wdata = '0;
    logic        in_ds = 1'b0, wen = 1'b0;
    logic [5:0]  int_in = '0;
    logic [4:0]  waddr = '0, raddr = '0;
    int n_chk = 0;
    int n_err = 0;

    cp0_ctrl_if #(.HW_INT_NUM(6)) ifa ();
    cp0_ctrl_if #(.HW_INT_NUM(3)) ifb ();

    assign ifa.commit_i = commit;  assign ifb.commit_i = commit;
    assign ifa.exc_req_i = exc_req; assign ifb.exc_req_i = exc_req;
    assign ifa.pc_i = pc;          assign ifb.pc_i = pc;
    assign ifa.bad_addr_i = bad_addr; assign ifb.bad_addr_i = bad_addr;
    assign ifa.in_delayslot_i = in_ds; assign ifb.in_delayslot_i = in_ds;
    assign ifa.int_i = int_in;     assign ifb.int_i = int_in[2:0];
    assign ifa.wen_i = wen;        assign ifb.wen_i = wen;
    assign ifa.waddr_i = waddr;    assign ifb.waddr_i = waddr;
    assign ifa.wdata_i = wdata;    assign ifb.wdata_i = wdata;
    assign ifa.raddr_i = raddr;    assign ifb.raddr_i = raddr;

    cp0_ctrl #(.HW_INT_NUM(6), .COUNT_DIV(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    cp0_ctrl #(.HW_INT_NUM(3), .COUNT_DIV(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; #2; rst = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rdb(input string tag, input logic [4:0] a, input logic [31:0] exp);
        raddr = a; #1;
        check(tag, ifb.rdata_o, exp);
    endtask

    task automatic commit_evt(input logic [7:0] req, input logic [31:0] p, input logic ds);
        commit = 1'b1; exc_req = req; pc = p; in_ds = ds;
        tick();
        commit = 1'b0; exc_req = '0; in_ds = 1'b0;
    endtask

    initial begin
        // reset state and prescaler
        do_reset();
        check("rst_flush", 32'(ifa.flush_o), 32'd0);
        check("rst_flush_pc", ifa.flush_pc_o, 32'd0);
        check("rst_ti", 32'(ifa.timer_int_o), 32'd0);
        raddr = 5'd12; #1; check("rst_status", ifa.rdata_o, 32'h0040_0000);
        raddr = 5'd9;  #1; check("rst_count", ifa.rdata_o, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a_no_flush", 32'(ifa.flush_o), 32'd0);
        end
        check("a_count_div2", ifa.rdata_o, 32'd5);
        check("b_count_div1", ifb.rdata_o, 32'd10);

        // timer match, sticky TI, clear on Compare write, Count wrap
        do_reset();
        wr(5'd11, 32'd8);
        wr(5'd9, 32'd6);
        check("ti_pre0", 32'(ifb.timer_int_o), 32'd0);
        tick(); check("ti_pre1", 32'(ifb.timer_int_o), 32'd0);
        tick(); check("ti_set", 32'(ifb.timer_int_o), 32'd1);
        tick(); tick(); check("ti_sticky", 32'(ifb.timer_int_o), 32'd1);
        wr(5'd11, 32'd100);
        check("ti_clr", 32'(ifb.timer_int_o), 32'd0);
        wr(5'd9, 32'hffff_ffff);
        tick(); rdb("count_wrap", 5'd9, 32'd0);

        // timer interrupt taken at commit
        do_reset();
        wr(5'd12, 32'h0000_8001);
        rdb("status_wr", 5'd12, 32'h0040_8001);
        wr(5'd11, 32'd20);
        wr(5'd9, 32'd18);
        tick(); tick();
        check("int_pend", 32'(ifb.int_pending_o), 32'd1);
        commit_evt(8'h00, 32'h8000_1000, 1'b0);
        check("int_flush", 32'(ifb.flush_o), 32'd1);
        check("int_flush_pc", ifb.flush_pc_o, 32'hbfc0_0380);
        rdb("int_epc", 5'd14, 32'h8000_1000);
        rdb("int_cause", 5'd13, 32'h4000_0000);
        rdb("int_status", 5'd12, 32'h0040_8003);
        check("int_masked_exl", 32'(ifb.int_pending_o), 32'd0);
        tick(); check("flush_one_cycle", 32'(ifb.flush_o), 32'd0);

        // ri beats ades, delay slot
        wr(5'd12, 32'h0000_0000);
        bad_addr = 32'h1234_5678;
        commit_evt(8'b0100_0010, 32'h8000_2004, 1'b1);
        check("ri_flush", 32'(ifb.flush_o), 32'd1);
        rdb("ri_cause", 5'd13, 32'hc000_0028);
        rdb("ri_epc", 5'd14, 32'h8000_2000);
        rdb("ri_badv", 5'd8, 32'd0);
        rdb("ri_status", 5'd12, 32'h0040_0002);

        // nested exception with EXL=1, then ERET
        commit_evt(8'h08, 32'h8000_3000, 1'b0);
        check("b2b_flush", 32'(ifb.flush_o), 32'd1);
        rdb("sys_epc_kept", 5'd14, 32'h8000_2000);
        rdb("sys_cause", 5'd13, 32'hc000_0020);
        commit_evt(8'h01, 32'h8000_3004, 1'b0);
        check("eret_flush", 32'(ifb.flush_o), 32'd1);
        check("eret_pc", ifb.flush_pc_o, 32'h8000_2000);
        rdb("eret_status", 5'd12, 32'h0040_0000);
        wen = 1'b1; waddr = 5'd14; wdata = 32'h8000_4444;
        commit_evt(8'h01, 32'h8000_3008, 1'b0);
        wen = 1'b0;
        check("eret_byp_pc", ifb.flush_pc_o, 32'h8000_4444);
        rdb("eret_epc_kept", 5'd14, 32'h8000_2000);

        // adel_mem records the data address
        bad_addr = 32'hdead_beef;
        commit_evt(8'h04, 32'h8000_5000, 1'b0);
        rdb("adelm_badv", 5'd8, 32'hdead_beef);
        rdb("adelm_cause", 5'd13, 32'h4000_0010);
        rdb("adelm_epc", 5'd14, 32'h8000_5000);

        // MTC0 squashed by ov; Cause bypass; hw lines above HW_INT_NUM
        wen = 1'b1; waddr = 5'd12; wdata = 32'h0000_ff01;
        commit_evt(8'h20, 32'h8000_6000, 1'b0);
        wen = 1'b0;
        rdb("ov_status", 5'd12, 32'h0040_0002);
        rdb("ov_cause", 5'd13, 32'h4000_0030);
        wen = 1'b1; waddr = 5'd13; wdata = 32'h0000_0300;
        rdb("cause_byp", 5'd13, 32'h4000_0330);
        int_in = 6'h3f;
        tick();
        wen = 1'b0;
        rdb("cause_hw", 5'd13, 32'h4000_1f30);
        int_in = 6'h00;

        // adel_if wins all, BadVAddr=pc; then reset mid-flush
        commit_evt(8'hff, 32'h8000_7000, 1'b0);
        rdb("adelif_badv", 5'd8, 32'h8000_7000);
        rdb("adelif_cause", 5'd13, 32'h4000_0310);
        check("pre_rst_flush", 32'(ifb.flush_o), 32'd1);
        rst = 1'b0; #1;
        check("rst_mid_flush", 32'(ifb.flush_o), 32'd0);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Parametrised CP0 system-control block, successor of the fixed single-configuration CP0.
- Sits at the commit (MEM/WB) boundary of the pipeline.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, prioritises committed exceptions and interrupts, and generates a registered one-cycle flush with a redirect PC.
- Adds over the previous generation: configurable hardware-interrupt width, Count prescaler, sticky timer interrupt (Cause.TI), masked-interrupt gating by IE/EXL, and a configurable exception vector.

Parameters:
HW_INT_NUM, 6, number of hardware interrupt lines mapped to Cause.IP[15:10] (1..6; unused IP bits read 0)
COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles (1..16)
EXC_VECTOR, 32'hbfc0_0380, redirect PC for every exception and interrupt
TIMER_IP, 1, 1: Cause.TI is ORed into IP[7] before interrupt masking; 0: timer reported only on timer_int_o
STATUS_RESET, 32'h0040_0000, Status value at reset (BEV=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
commit_i  input  1  an instruction commits this cycle; exceptions and interrupts are sampled only when high
exc_req_i  input  8  {adel_if, ri, ov, bp, sys, adel_mem, ades, eret}, bit 7 highest priority
pc_i  input  32  PC of the committing instruction
bad_addr_i  input  32  faulting data address (adel_mem/ades)
in_delayslot_i  input  1  committing instruction is in a delay slot
int_i  input  HW_INT_NUM  level hardware interrupts, synchronised externally
wen_i  input  1  MTC0 write enable
waddr_i  input  5  write register number
wdata_i  input  32  write data
raddr_i  input  5  read register number
rdata_o  output  32  combinational read data, with bypass
flush_o  output  1  registered, one-cycle pipeline flush
flush_pc_o  output  32  registered redirect PC, valid when flush_o=1
int_pending_o  output  1  combinational: unmasked interrupt pending
timer_int_o  output  1  Cause.TI

Behaviour:
- Reset (rst=0, asynchronous): all registers 0 except Status=STATUS_RESET; prescaler 0; flush_o=0, flush_pc_o=0, timer_int_o=0.
- Register map:
  - 8 BadVAddr, read-only.
  - 9 Count, read/write.
  - 11 Compare, read/write.
  - 12 Status: writable IM[15:8], EXL[1], IE[0]; all other bits hold their values.
  - 13 Cause: writable IP[9:8] only; BD[31], TI[30], IP[15:10], ExcCode[6:2] are hardware-owned.
  - 14 EPC, read/write.
  - Any other address reads 0; writes to it are ignored.
- Read bypass: if wen_i and waddr_i==raddr_i, rdata_o returns the stored value with the writable bits replaced by wdata_i.
- Cause.IP[15:10] is resampled from int_i every cycle; bits above HW_INT_NUM read 0.
- Count and prescaler:
  - Prescaler counts 0..COUNT_DIV-1; Count increments by 1 on wrap and wraps 0xFFFFFFFF -> 0.
  - A write to Count loads wdata_i and clears the prescaler; a write beats an increment in the same cycle.
- Timer:
  - TI is set on the edge where the updated Count equals Compare.
  - TI stays set until Compare is written.
  - A Compare write clears TI even if a match occurs in the same cycle.
- Interrupt pending: int_pending_o = IE & ~EXL & |(IP_eff[15:8] & IM), where IP_eff[7] = IP[7] | (TIMER_IP & TI).
- Event selection (only when commit_i=1), priority: interrupt > adel_if > ri > ov > bp > sys > adel_mem > ades > eret. At most one event per cycle.
  - ExcCode values: Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0a, Ov 0x0c.
- Exception or interrupt taken:
  - If EXL=0: EPC = pc_i-4 with BD=1 when in_delayslot_i, else EPC = pc_i with BD=0. If EXL=1, EPC and BD are unchanged.
  - EXL=1; ExcCode set.
  - BadVAddr = pc_i for adel_if; BadVAddr = bad_addr_i for adel_mem/ades.
  - Next cycle: flush_o=1, flush_pc_o=EXC_VECTOR.
- ERET taken: EXL=0. Next cycle: flush_o=1, flush_pc_o = EPC (value before this edge, including a same-cycle bypassed EPC write).
- Simultaneous events:
  - When any event is taken, the same-cycle MTC0 write is discarded. The exception is the EPC write covered by the ERET case above: it is discarded as a register write but its value supplies flush_pc_o.
  - Count increment and TI logic are unaffected by events.
- flush_o is exactly one cycle wide; back-to-back events give back-to-back pulses.
- Reset mid-flush forces flush_o=0 immediately.

Test Plan:
- Reset then 10 cycles with COUNT_DIV=2 -> Count=5, Status=0x00400000, flush_o never 1.
- Compare=8, Count=6, COUNT_DIV=1 -> TI=1 two cycles later and stays 1; Compare write -> TI=0 at the next edge.
- Status=0x00008001, Compare match with TIMER_IP=1, commit_i=1 at pc 0x80001000 -> int_pending_o=1; EPC=0x80001000, ExcCode=0; next cycle flush_o=1, flush_pc_o=0xbfc00380.
- exc_req_i={ri,ades} at pc 0x80002004 in delay slot -> ExcCode=0x0a, EPC=0x80002000, BD=1, BadVAddr unchanged.
- Second exception with EXL=1 -> EPC unchanged; ERET -> flush_pc_o=EPC, EXL=0.
- Same-cycle MTC0 Status write + ov exception -> write discarded, ExcCode=0x0c; same-cycle write+read of Cause 0x300 -> rdata_o IP[9:8]=2'b11.
